// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with hold / +4 / redirect next-PC selection.
// With FETCH_MISALIGN_CHK_EN a misaligned redirect target is flagged and not taken.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        redirect_misaligned,
`endif
  output logic [31:0] pc
);

  logic take_redirect;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign take_redirect       = redirect_valid && !redirect_misaligned;
`else
  assign take_redirect       = redirect_valid;
`endif

  // Low bits are forced to zero on every load so pc stays word aligned.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pc <= {RESET_PC[31:2], 2'b00};
    else if (take_redirect)
      pc <= {redirect_pc[31:2], 2'b00};
    else if (advance)
      pc <= pc + PC_STEP;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: boot/run FSM, registered fetch slot, decode handshake.
// Optional misaligned-redirect fault handling under FETCH_MISALIGN_CHK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        misalign_fault,
  output logic [31:0] misalign_pc,
`endif
  output logic [31:0] if_pc4
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         load;
  logic         advance;
`ifdef FETCH_MISALIGN_CHK_EN
  logic         redirect_misaligned;
`endif

  assign load      = !if_valid || if_ready;
  assign advance   = (state == RUN) && load && !redirect_valid;
  assign imem_addr = pc;
  assign if_pc4    = if_pc + PC_STEP;

  fetch_pc_gen #(
    .RESET_PC            (RESET_PC)
  ) u_pc_gen (
    .clk                 (clk),
    .rst_n               (rst_n),
    .advance             (advance),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
`ifdef FETCH_MISALIGN_CHK_EN
    .redirect_misaligned (redirect_misaligned),
`endif
    .pc                  (pc)
  );

  // Redirect wins over every state; the slot is flushed even if decode takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_fault <= 1'b0;
      misalign_pc    <= 32'h0;
`endif
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_misaligned) begin
        state          <= FAULT;
        misalign_fault <= 1'b1;
        misalign_pc    <= redirect_pc;
      end else begin
        state          <= RUN;
        misalign_fault <= 1'b0;
      end
`else
      state <= RUN;
`endif
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (load) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_inst  <= imem_inst;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural fetch model.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_ready = 1'b1;
  logic [31:0] imem_addr, imem_inst, if_pc, if_inst, if_pc4;
  logic        if_valid;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_fault;
  logic [31:0] misalign_pc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory: word k holds value k.
  assign imem_inst = {2'b00, imem_addr[31:2]};

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_fault (misalign_fault),
    .misalign_pc    (misalign_pc),
`endif
    .if_pc4         (if_pc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: next fetch address, slot contents, boot and fault flags.
  logic [31:0] m_pc = RPC, m_spc = 32'h0, m_sinst = 32'h13, m_fpc = 32'h0;
  bit          m_valid = 1'b0, m_boot = 1'b1, m_fault = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= RPC; m_valid <= 1'b0; m_spc <= 32'h0; m_sinst <= 32'h13;
      m_boot <= 1'b1; m_fault <= 1'b0; m_fpc <= 32'h0;
    end else if (redirect_valid) begin
      m_valid <= 1'b0;
      m_boot  <= 1'b0;
      if (CHK && redirect_pc[1:0] != 2'b00) begin
        m_fault <= 1'b1;
        m_fpc   <= redirect_pc;
      end else begin
        m_fault <= 1'b0;
        m_pc    <= redirect_pc & 32'hFFFF_FFFC;
      end
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (!m_fault && (!m_valid || if_ready)) begin
      m_spc   <= m_pc;
      m_sinst <= m_pc >> 2;
      m_valid <= 1'b1;
      m_pc    <= m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_if_pc", if_pc, m_spc);
    chk("m_if_inst", if_inst, m_sinst);
    chk("m_if_pc4", if_pc4, m_spc + 32'd4);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("m_fault", {31'b0, misalign_fault}, {31'b0, m_fault});
    chk("m_fault_pc", misalign_pc, m_fpc);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string name, input logic [31:0] pc, input logic [31:0] inst);
    chk({name, "_valid"}, {31'b0, if_valid}, 32'd1);
    chk({name, "_pc"}, if_pc, pc);
    chk({name, "_inst"}, if_inst, inst);
  endtask

  initial begin
    logic [31:0] tgt;
    // Reset state
    repeat (2) step();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, 32'h13);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h100);

    // Boot: one idle edge, then fetch at RESET_PC
    rst_n = 1'b1;
    step();
    chk("boot_valid", {31'b0, if_valid}, 32'd0);
    chk("boot_addr", imem_addr, 32'h100);
    step(); slot("first", 32'h100, 32'h40);
    step(); slot("second", 32'h104, 32'h41);
    step(); slot("third", 32'h108, 32'h42);

    // Stall for 3 cycles
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      slot("stall", 32'h108, 32'h42);
      chk("stall_addr", imem_addr, 32'h10C);
    end
    if_ready = 1'b1;
    step(); slot("release", 32'h10C, 32'h43);

    // Redirect with concurrent accept
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    chk("redir_flush", {31'b0, if_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h200);
    redirect_valid = 1'b0;
    step(); slot("redir_tgt", 32'h200, 32'h80);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step(); slot("wrap0", 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    step(); slot("wrap1", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    chk("wrap_pc4", if_pc4, 32'h0);
    step(); slot("wrap2", 32'h0, 32'h0);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    step();
    chk("mis_flush", {31'b0, if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_fault", {31'b0, misalign_fault}, 32'd1);
    chk("mis_pc", misalign_pc, 32'h202);
    redirect_valid = 1'b0;
    step();
    chk("mis_hold", {31'b0, if_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h305;
    step();
    chk("mis_upd", misalign_pc, 32'h305);
    redirect_pc = 32'h300;
    step();
    chk("mis_clear", {31'b0, misalign_fault}, 32'd0);
    chk("mis_clr_valid", {31'b0, if_valid}, 32'd0);
    chk("mis_clr_addr", imem_addr, 32'h300);
    redirect_valid = 1'b0;
    step(); slot("mis_tgt", 32'h300, 32'hC0);
`else
    chk("mis_addr", imem_addr, 32'h200);
    redirect_valid = 1'b0;
    step(); slot("mis_tgt", 32'h200, 32'h80);
`endif

    // Reset during stall
    if_ready = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("rst_stall_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_stall_inst", if_inst, 32'h13);
    chk("rst_stall_addr", imem_addr, 32'h100);
    rst_n = 1'b1; if_ready = 1'b1;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: tgt = {20'h0, $urandom_range(0, 1023) * 4};
        1: tgt = {20'h0, $urandom_range(0, 4095)};
        2: tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
        default: tgt = $urandom;
      endcase
      redirect_pc = tgt;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
